// File: rtl/linalg_pkg.sv
// Shared linear-algebra definitions: datapath word width and the
// load/drain state encoding used by the streaming transpose controller.
package linalg_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        ST_LOAD,
        ST_DRAIN
    } xpose_state_t;

endpackage

// File: rtl/mat_transpose.sv
// Combinational M x N matrix transpose: mat_t[j][i] = mat[i][j].
// Pure wiring; the controller adds all sequencing.
module mat_transpose
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3
) (
    input  logic [M-1:0][N-1:0][WORD_W-1:0] mat,
    output logic [N-1:0][M-1:0][WORD_W-1:0] mat_t
);

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign mat_t[j][i] = mat[i][j];
        end
    end

endmodule

// File: rtl/mat_transpose_stream_ctrl.sv
// Streaming transpose: buffers M input rows of N words, then emits the N
// columns as M-word output rows. Both sides use valid/ready handshakes.
module mat_transpose_stream_ctrl
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0][WORD_W-1:0]     in_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [M-1:0][WORD_W-1:0]     out_row,
    output logic                         busy,
    output logic                         done
);

    // Handshake rule on both ports: a beat transfers on a rising edge where
    // valid and ready are both high; out_valid/out_row stay put until then.
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    xpose_state_t state, state_nxt;
    logic [RW-1:0] r_cnt;
    logic [CW-1:0] c_cnt;
    logic [M-1:0][N-1:0][WORD_W-1:0] row_buf;
    logic [N-1:0][M-1:0][WORD_W-1:0] transposed;

    logic in_hs, out_hs, r_last, c_last;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign r_last = (r_cnt == RW'(M - 1));
    assign c_last = (c_cnt == CW'(N - 1));

    mat_transpose #(
        .M(M),
        .N(N)
    ) genloop_xpose (
        .mat   (row_buf),
        .mat_t (transposed)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else if (clear) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (in_hs && r_last)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_hs && c_last) state_nxt = ST_LOAD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_LOAD);
        out_valid = (state == ST_DRAIN);
        busy      = (state == ST_DRAIN) || (r_cnt != '0);
        out_row   = '0;
        if (state == ST_DRAIN) out_row = transposed[c_cnt];
    end

    // Clear keeps the buffer contents; they are overwritten before reuse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            c_cnt   <= '0;
            done    <= 1'b0;
            row_buf <= '0;
        end else if (clear) begin
            r_cnt <= '0;
            c_cnt <= '0;
            done  <= 1'b0;
        end else begin
            done <= out_hs && c_last;
            if (in_hs) begin
                row_buf[r_cnt] <= in_row;
                if (r_last) begin
                    r_cnt <= '0;
                    c_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + RW'(1);
                end
            end
            if (out_hs) begin
                c_cnt <= c_last ? '0 : c_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mat_transpose_stream_ctrl.sv
// Directed bench for the streaming transpose controller: M=2,N=3 main
// instance plus M=1,N=1 and M=4,N=1 corner instances.
module tb_mat_transpose_stream_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt;
    logic [63:0] exp_q[$];

    // main instance, M=2 N=3
    logic               clear, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [2:0][31:0]   in_row;
    logic [1:0][31:0]   out_row;

    // corner instance, M=1 N=1
    logic               in_valid1, in_ready1, out_valid1, out_ready1, busy1, done1;
    logic [0:0][31:0]   in_row1;
    logic [0:0][31:0]   out_row1;

    // corner instance, M=4 N=1
    logic               in_valid4, in_ready4, out_valid4, out_ready4, busy4, done4;
    logic [0:0][31:0]   in_row4;
    logic [3:0][31:0]   out_row4;

    mat_transpose_stream_ctrl #(.M(2), .N(3)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .busy(busy), .done(done)
    );

    mat_transpose_stream_ctrl #(.M(1), .N(1)) dut_1x1 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_row(in_row1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_row(out_row1),
        .busy(busy1), .done(done1)
    );

    mat_transpose_stream_ctrl #(.M(4), .N(1)) dut_4x1 (
        .clk(clk), .rst_n(rst_n), .clear(1'b0),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_row(in_row4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_row(out_row4),
        .busy(busy4), .done(done4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done pulses are counted from the value held across each edge
    always @(posedge clk) begin
        if (!rst_n) done_cnt <= 0;
        else if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: present one row and hold it until it is accepted
    task automatic send_row(input string tag, input logic [2:0][31:0] row);
        int cyc;
        cyc      = 0;
        in_valid = 1'b1;
        in_row   = row;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!in_ready) chk({tag, "_in_ready_timeout"}, 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // consumer: out_ready follows pat (LSB first, then 1); checks beats
    // against exp_q and that stalled beats stay unchanged
    task automatic collect(input string tag, input int nbeats, input logic [15:0] pat,
                           output int cycles);
        int          got;
        logic        stalled;
        logic [63:0] held;
        got     = 0;
        cycles  = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < nbeats && cycles < 50) begin
            out_ready = (cycles < 16) ? pat[cycles] : 1'b1;
            chk({tag, "_out_valid"}, out_valid, 1);
            chk({tag, "_in_ready_low"}, in_ready, 0);
            if (stalled) chk({tag, "_held"}, out_row, held);
            if (out_ready) begin
                if (exp_q.size() == 0) chk({tag, "_exp_q_empty"}, 1, 0);
                else chk({tag, "_beat"}, out_row, exp_q.pop_front());
                got++;
                stalled = 1'b0;
            end else begin
                held    = out_row;
                stalled = 1'b1;
            end
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        if (got < nbeats) chk({tag, "_drain_timeout"}, got, nbeats);
    endtask

    initial begin
        int cyc;
        int d0;
        checks = 0; errors = 0;
        rst_n = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in_row1 = '0; out_ready1 = 1'b0;
        in_valid4 = 1'b0; in_row4 = '0; out_ready4 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // 1: basic transpose, consumer always ready
        send_row("t1_r0", {32'd3, 32'd2, 32'd1});
        chk("t1_busy_mid", busy, 1);
        chk("t1_in_ready_mid", in_ready, 1);
        chk("t1_out_valid_mid", out_valid, 0);
        send_row("t1_r1", {32'd6, 32'd5, 32'd4});
        exp_q.push_back({32'd4, 32'd1});
        exp_q.push_back({32'd5, 32'd2});
        exp_q.push_back({32'd6, 32'd3});
        collect("t1", 3, 16'hFFFF, cyc);
        chk("t1_cycles", cyc, 3);
        chk("t1_done", done, 1);
        chk("t1_in_ready_after", in_ready, 1);
        chk("t1_out_valid_after", out_valid, 0);
        tick();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_done_cnt", done_cnt, 1);

        // 2: consumer stalls with pattern 1,0,0,1,0,1
        send_row("t2_r0", {32'd3, 32'd2, 32'd1});
        send_row("t2_r1", {32'd6, 32'd5, 32'd4});
        exp_q.push_back({32'd4, 32'd1});
        exp_q.push_back({32'd5, 32'd2});
        exp_q.push_back({32'd6, 32'd3});
        collect("t2", 3, 16'b0000_0000_0010_1001, cyc);
        chk("t2_cycles", cyc, 6);
        chk("t2_done", done, 1);
        tick();
        chk("t2_done_cnt", done_cnt, 2);

        // 3: input bubbles, then two matrices back to back
        d0 = done_cnt;
        send_row("t3_a0", {32'd3, 32'd2, 32'd1});
        tick();
        tick();
        chk("t3_bubble_busy", busy, 1);
        chk("t3_bubble_in_ready", in_ready, 1);
        chk("t3_bubble_out_valid", out_valid, 0);
        send_row("t3_a1", {32'd6, 32'd5, 32'd4});
        exp_q.push_back({32'd4, 32'd1});
        exp_q.push_back({32'd5, 32'd2});
        exp_q.push_back({32'd6, 32'd3});
        collect("t3a", 3, 16'hFFFF, cyc);
        chk("t3_in_ready_no_bubble", in_ready, 1);
        send_row("t3_b0", {32'd9, 32'd8, 32'd7});
        send_row("t3_b1", {32'd12, 32'd11, 32'd10});
        exp_q.push_back({32'd10, 32'd7});
        exp_q.push_back({32'd11, 32'd8});
        exp_q.push_back({32'd12, 32'd9});
        collect("t3b", 3, 16'hFFFF, cyc);
        tick();
        chk("t3_done_twice", done_cnt - d0, 2);

        // 4: clear after one row; a row offered in the clear cycle is dropped
        send_row("t4_r0", {32'd3, 32'd2, 32'd1});
        chk("t4_busy_before_clear", busy, 1);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_row   = {32'd99, 32'd98, 32'd97};
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t4_busy_after_clear", busy, 0);
        chk("t4_in_ready_after_clear", in_ready, 1);
        chk("t4_out_valid_after_clear", out_valid, 0);
        send_row("t4_r1", {32'd6, 32'd5, 32'd4});
        chk("t4_not_drain_yet", out_valid, 0);
        send_row("t4_r2", {32'd9, 32'd8, 32'd7});
        exp_q.push_back({32'd7, 32'd4});
        exp_q.push_back({32'd8, 32'd5});
        exp_q.push_back({32'd9, 32'd6});
        collect("t4", 3, 16'hFFFF, cyc);

        // 5: reset in the middle of a drain
        tick();
        send_row("t5_r0", {32'd3, 32'd2, 32'd1});
        send_row("t5_r1", {32'd6, 32'd5, 32'd4});
        out_ready = 1'b1;
        chk("t5_first_beat", out_row, {32'd4, 32'd1});
        tick();
        out_ready = 1'b0;
        chk("t5_second_beat", out_row, {32'd5, 32'd2});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_row", out_row, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_done", done, 0);
        chk("t5_busy", busy, 0);
        send_row("t5_f0", {32'd12, 32'd11, 32'd10});
        send_row("t5_f1", {32'd15, 32'd14, 32'd13});
        exp_q.push_back({32'd13, 32'd10});
        exp_q.push_back({32'd14, 32'd11});
        exp_q.push_back({32'd15, 32'd12});
        collect("t5", 3, 16'hFFFF, cyc);
        chk("t5_done_after", done, 1);

        // 6a: M=1, N=1
        in_valid1 = 1'b1;
        in_row1   = 32'd42;
        tick();
        in_valid1 = 1'b0;
        chk("t6a_out_valid", out_valid1, 1);
        chk("t6a_out_row", out_row1, 32'd42);
        chk("t6a_in_ready", in_ready1, 0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("t6a_done", done1, 1);
        chk("t6a_out_valid_after", out_valid1, 0);
        chk("t6a_in_ready_after", in_ready1, 1);
        tick();
        chk("t6a_done_clear", done1, 0);

        // 6b: M=4, N=1
        in_valid4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_row4 = 32'hA0 + 32'(k);
            tick();
            if (k == 2) chk("t6b_busy_mid", busy4, 1);
        end
        in_valid4 = 1'b0;
        chk("t6b_out_valid", out_valid4, 1);
        chk("t6b_out_row", out_row4, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("t6b_done", done4, 1);
        chk("t6b_in_ready_after", in_ready4, 1);
        chk("t6b_busy_after", busy4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
